// File: rtl/req_capture_enc4_pkg.sv
// Purpose : shared constants, FSM state encoding and a one-hot helper for the
//           request-capture front end of the 4:2 encoder.
// Latency : n/a (declarations only). Backpressure: n/a.
package en_pkg;

  localparam int NUM_REQ = 4;  // request lines; fixed at 4 for this revision
  localparam int IDX_W   = 2;  // log2(NUM_REQ)

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Bit mask with only position idx set; used to clear the served pending bit.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/req_capture_enc4_if.sv
// Purpose : request/encoded-event bundle between the request source + consumer
//           (master side) and req_capture_enc4 (slave side).
// Latency : n/a. Backpressure: out_valid/out_ready handshake on idx.
// Signals : req[3:0] async level inputs, out_ready consumer accept,
//           out_valid/idx encoded event, pending[3:0] status, overflow pulse.
interface req_capture_enc4_if;
  import en_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               out_ready;
  logic               out_valid;
  logic [IDX_W-1:0]   idx;
  logic [NUM_REQ-1:0] pending;
  logic               overflow;

  // Source/consumer side: drives requests and ready, observes the event stream.
  modport master (
    output req, out_ready,
    input  out_valid, idx, pending, overflow
  );

  // Capture block side.
  modport slave (
    input  req, out_ready,
    output out_valid, idx, pending, overflow
  );

endinterface

// File: rtl/req_capture_enc4_rr_pick4.sv
// Purpose : combinational round-robin picker; first set bit of vec scanning
//           start, start+1, ... mod 4.
// Latency : 0 cycles (pure comb). Backpressure: none.
// Ports   : vec[3:0] candidates, start[1:0] scan origin, idx[1:0] winner,
//           any = vec has at least one bit set.
module rr_pick4
  import en_pkg::*;
(
  input  logic [NUM_REQ-1:0] vec,
  input  logic [IDX_W-1:0]   start,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest offset down to offset 0 so the closest set bit to
  // start is the last assignment and therefore wins. Index arithmetic wraps
  // naturally in IDX_W bits.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = start + IDX_W'(k);
      if (vec[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_capture_enc4.sv
// Purpose : synchronise 4 async request lines, capture rising edges as sticky
//           pending bits, serve them round-robin as a registered 2-bit index.
// Latency : req_s edge -> pending +1 cycle -> out_valid +2 cycles (pin adds SYNC_STAGES).
// Backpres: idx held stable while out_ready=0; repeat edges on a pending line
//           are dropped and flagged by a one-cycle overflow pulse.
// Ports   : clk, rst (async active-high), bus (slave modport: req, out_ready in;
//           out_valid, idx, pending, overflow out).
module req_capture_enc4
  import en_pkg::*;
#(
  parameter int SYNC_STAGES = 2  // legal range 1..3
) (
  input logic         clk,
  input logic         rst,
  req_capture_enc4_if.slave bus
);

  logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_REQ-1:0] req_s;
  logic [NUM_REQ-1:0] req_q;
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clr;
  logic [NUM_REQ-1:0] nxt;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic               accept;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   idx_inc;
  logic               out_valid_q, out_valid_d;

  logic [NUM_REQ-1:0] pick_vec;
  logic [IDX_W-1:0]   pick_start;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  // Synchroniser and edge-detect history. req_q resets to 0, so a line held
  // high across reset release is seen as one fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      req_q <= '0;
    end else begin
      sync_q[0] <= bus.req;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      req_q <= req_s;
    end
  end

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign rise    = req_s & ~req_q;
  assign accept  = out_valid_q & bus.out_ready;
  assign clr     = accept ? onehot(idx_q) : '0;
  assign nxt     = pending_q & ~clr;
  // A rise on the bit being cleared this cycle survives as a new event.
  assign pending_d  = nxt | rise;
  assign overflow_d = |(rise & nxt);
  assign idx_inc    = idx_q + IDX_W'(1);

  // One picker shared by both states: IDLE scans all pending from ptr, HOLD
  // scans what remains after this accept, starting just past the served line.
  // Same-cycle rises are deliberately excluded from the HOLD scan.
  assign pick_vec   = (state_q == ST_HOLD) ? nxt : pending_q;
  assign pick_start = (state_q == ST_HOLD) ? idx_inc : ptr_q;

  rr_pick4 u_pick (
    .vec   (pick_vec),
    .start (pick_start),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pick_any)             state_d = ST_HOLD;
      ST_HOLD: if (accept && !pick_any)  state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM outputs (next values of the registered outputs and the rr pointer).
  always_comb begin
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    out_valid_d = (state_d == ST_HOLD);
    case (state_q)
      ST_IDLE: begin
        if (pick_any) idx_d = pick_idx;
      end
      ST_HOLD: begin
        if (accept) begin
          ptr_d = idx_inc;
          if (pick_any) idx_d = pick_idx;
        end
      end
      default: begin
        idx_d = '0;
        ptr_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      idx_q       <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.idx       = idx_q;
  assign bus.pending   = pending_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_req_capture_enc4.sv
// Purpose : directed self-checking bench for req_capture_enc4.
// Latency : inputs change on the falling edge, outputs sampled on the falling edge.
// Backpres: out_ready driven directly from the stimulus sequence.
module tb_req_capture_enc4;
  import en_pkg::*;

  localparam int SYNC = 2;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  req_capture_enc4_if bus_if ();

  req_capture_enc4 #(.SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int first_k;
    int beats;
    logic [IDX_W-1:0] first_idx;
    logic [IDX_W-1:0] seq [3];
    int seq_t [3];

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus_if.req = '0;
    bus_if.out_ready = 1'b0;

    // 1: reset state
    do_reset();
    chk("rst_out_valid", bus_if.out_valid, 0);
    chk("rst_idx",       bus_if.idx,       0);
    chk("rst_pending",   bus_if.pending,   0);
    chk("rst_overflow",  bus_if.overflow,  0);

    // 2: single 3-cycle pulse on req[2]
    bus_if.out_ready = 1'b1;
    bus_if.req = 4'b0100;
    first_k = 0; first_idx = '0; beats = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) bus_if.req = 4'b0000;
      if (bus_if.out_valid && first_k == 0) begin
        first_k = k;
        first_idx = bus_if.idx;
      end
      if (bus_if.out_valid && bus_if.out_ready) beats++;
    end
    chk("t2_latency", first_k, SYNC + 2);
    chk("t2_idx",     first_idx, 2);
    chk("t2_beats",   beats, 1);
    chk("t2_pending", bus_if.pending, 0);

    // 3: three lines rise together, from ptr=0
    do_reset();
    bus_if.out_ready = 1'b1;
    bus_if.req = 4'b1011;
    beats = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 3) bus_if.req = 4'b0000;
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (beats < 3) begin
          seq[beats] = bus_if.idx;
          seq_t[beats] = k;
        end
        beats++;
      end
    end
    chk("t3_beats", beats, 3);
    chk("t3_idx0",  seq[0], 0);
    chk("t3_idx1",  seq[1], 1);
    chk("t3_idx2",  seq[2], 3);
    chk("t3_b2b",   seq_t[2] - seq_t[0], 2);
    chk("t3_valid_end", bus_if.out_valid, 0);

    // 4: idx=1 held with out_ready=0, second req[1] edge overflows
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b0010;
    tick(); tick();
    bus_if.req = 4'b0000;
    tick(); tick();
    chk("t4_valid", bus_if.out_valid, 1);
    chk("t4_idx",   bus_if.idx, 1);
    bus_if.req = 4'b0010;
    tick(); tick();
    chk("t4_ovf_pre", bus_if.overflow, 0);
    tick();
    chk("t4_ovf_pulse", bus_if.overflow, 1);
    chk("t4_idx_held",  bus_if.idx, 1);
    tick();
    chk("t4_ovf_post", bus_if.overflow, 0);
    bus_if.out_ready = 1'b1;
    bus_if.req = 4'b0000;
    beats = 0; first_idx = '0;
    for (int k = 0; k < 10; k++) begin
      if (bus_if.out_valid && bus_if.out_ready) begin
        beats++;
        first_idx = bus_if.idx;
      end
      tick();
    end
    chk("t4_beats",    beats, 1);
    chk("t4_beat_idx", first_idx, 1);

    // 5: pending=0101 with ptr=2, fresh req[2] edge on the accept of 2
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b0101;
    tick(); tick(); tick(); tick();
    chk("t5_pending", bus_if.pending, 4'b0101);
    chk("t5_first",   bus_if.idx, 2);
    bus_if.req = 4'b0000;
    tick();
    bus_if.req = 4'b0100;
    tick(); tick();
    bus_if.out_ready = 1'b1;
    tick();
    chk("t5_second",      bus_if.idx, 0);
    chk("t5_pend_rearm",  bus_if.pending, 4'b0101);
    chk("t5_no_ovf",      bus_if.overflow, 0);
    tick();
    chk("t5_third",  bus_if.idx, 2);
    chk("t5_valid3", bus_if.out_valid, 1);
    tick();
    chk("t5_valid_end", bus_if.out_valid, 0);
    chk("t5_pend_end",  bus_if.pending, 0);

    // 6: async reset in the middle of HOLD
    bus_if.out_ready = 1'b0;
    bus_if.req = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("t6_hold_valid", bus_if.out_valid, 1);
    chk("t6_hold_idx",   bus_if.idx, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid",   bus_if.out_valid, 0);
    chk("t6_rst_pending", bus_if.pending, 0);
    tick();
    bus_if.req = 4'b0000;
    tick(); tick();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus_if.out_valid) beats++;
    end
    chk("t6_no_beat", beats, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
